// File: rtl/rv32_bus_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter onto one shared memory port, with a wait timeout.
// Tie-break is fixed DATA priority unless RV32_ARB_ROUND_ROBIN_EN is defined (alternating grants).
module rv32_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [31:0] instr_address_in,
    input  logic        instr_read_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,
    input  logic [31:0] data_address_in,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out,
    output logic [31:0] mem_address_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [3:0]  mem_write_mask_out,
    output logic [31:0] mem_write_value_out,
    input  logic [31:0] mem_read_value_in,
    input  logic        mem_ready_in,
    output logic        bus_error_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_req_c;
    logic             prefer_data_c;
    logic             grant_data_c;
    logic             timeout_c;

`ifdef RV32_ARB_ROUND_ROBIN_EN
    // 1 = DATA was granted last, 0 = INSTR
    logic last_data_q, last_data_d;
    assign prefer_data_c = ~last_data_q;
`else
    assign prefer_data_c = 1'b1;
`endif

    assign data_req_c   = data_read_in | data_write_in;
    assign grant_data_c = data_req_c & (~instr_read_in | prefer_data_c);
    assign timeout_c    = (cnt_q == CNT_W'(TIMEOUT)) & ~mem_ready_in;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef RV32_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`endif

    // Next state, wait counter and the combinational memory/response muxing
    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
`ifdef RV32_ARB_ROUND_ROBIN_EN
        last_data_d          = last_data_q;
`endif
        instr_read_value_out = '0;
        instr_ready_out      = 1'b0;
        data_read_value_out  = '0;
        data_ready_out       = 1'b0;
        mem_address_out      = '0;
        mem_read_out         = 1'b0;
        mem_write_out        = 1'b0;
        mem_write_mask_out   = '0;
        mem_write_value_out  = '0;
        bus_error_out        = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_data_c) begin
                    state_d = DATA;
                    cnt_d   = '0;
`ifdef RV32_ARB_ROUND_ROBIN_EN
                    last_data_d = 1'b1;
`endif
                end else if (instr_read_in) begin
                    state_d = INSTR;
                    cnt_d   = '0;
`ifdef RV32_ARB_ROUND_ROBIN_EN
                    last_data_d = 1'b0;
`endif
                end
            end
            INSTR: begin
                mem_address_out = instr_address_in;
                mem_read_out    = ~timeout_c;
                if (mem_ready_in) begin
                    instr_ready_out      = 1'b1;
                    instr_read_value_out = mem_read_value_in;
                    state_d              = IDLE;
                end else if (timeout_c) begin
                    instr_ready_out      = 1'b1;
                    instr_read_value_out = 32'hFFFF_FFFF;
                    bus_error_out        = 1'b1;
                    state_d              = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                mem_address_out     = data_address_in;
                mem_read_out        = data_read_in & ~timeout_c;
                mem_write_out       = data_write_in & ~timeout_c;
                mem_write_mask_out  = data_write_mask_in;
                mem_write_value_out = data_write_value_in;
                if (mem_ready_in) begin
                    data_ready_out      = 1'b1;
                    data_read_value_out = mem_read_value_in;
                    state_d             = IDLE;
                end else if (timeout_c) begin
                    data_ready_out      = 1'b1;
                    data_read_value_out = 32'hFFFF_FFFF;
                    bus_error_out       = 1'b1;
                    state_d             = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed bench for rv32_bus_arbiter with a response scoreboard (TIMEOUT=4).
module tb_rv32_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_;
    logic [31:0] instr_address_in;
    logic        instr_read_in;
    logic [31:0] instr_read_value_out;
    logic        instr_ready_out;
    logic [31:0] data_address_in;
    logic        data_read_in;
    logic        data_write_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_write_value_in;
    logic [31:0] data_read_value_out;
    logic        data_ready_out;
    logic [31:0] mem_address_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [3:0]  mem_write_mask_out;
    logic [31:0] mem_write_value_out;
    logic [31:0] mem_read_value_in;
    logic        mem_ready_in;
    logic        bus_error_out;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   nready;

    rv32_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk                 (clk),
        .reset_              (reset_),
        .instr_address_in    (instr_address_in),
        .instr_read_in       (instr_read_in),
        .instr_read_value_out(instr_read_value_out),
        .instr_ready_out     (instr_ready_out),
        .data_address_in     (data_address_in),
        .data_read_in        (data_read_in),
        .data_write_in       (data_write_in),
        .data_write_mask_in  (data_write_mask_in),
        .data_write_value_in (data_write_value_in),
        .data_read_value_out (data_read_value_out),
        .data_ready_out      (data_ready_out),
        .mem_address_out     (mem_address_out),
        .mem_read_out        (mem_read_out),
        .mem_write_out       (mem_write_out),
        .mem_write_mask_out  (mem_write_mask_out),
        .mem_write_value_out (mem_write_value_out),
        .mem_read_value_in   (mem_read_value_in),
        .mem_ready_in        (mem_ready_in),
        .bus_error_out       (bus_error_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic is_data, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        e.err     = err;
        return e;
    endfunction

    // Settle mid-cycle, then score any completed transaction
    task automatic sample();
        exp_t e;
        #3;
        chk("one_ready_at_a_time", 32'(instr_ready_out & data_ready_out), 32'd0);
        if (instr_ready_out || data_ready_out) begin
            chk("sb_expected_ready", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_master", 32'(data_ready_out), 32'(e.is_data));
                chk("sb_rdata", e.is_data ? data_read_value_out : instr_read_value_out, e.rdata);
                chk("sb_bus_error", 32'(bus_error_out), 32'(e.err));
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_mem_addr"}, mem_address_out, 32'd0);
        chk({tag, "_mem_rw"}, {30'd0, mem_read_out, mem_write_out}, 32'd0);
        chk({tag, "_mem_mask_val"}, {28'd0, mem_write_mask_out} | mem_write_value_out, 32'd0);
        chk({tag, "_readies_err"}, {29'd0, instr_ready_out, data_ready_out, bus_error_out}, 32'd0);
    endtask

    initial begin
        reset_              = 1'b0;
        instr_address_in    = 32'h100;
        instr_read_in       = 1'b1;
        data_address_in     = '0;
        data_read_in        = 1'b0;
        data_write_in       = 1'b0;
        data_write_mask_in  = '0;
        data_write_value_in = '0;
        mem_read_value_in   = '0;
        mem_ready_in        = 1'b1;

        // Reset holds everything quiet even with a request and ready present
        #3;
        all_zero("reset");
        next();
        reset_ = 1'b1;

        // Fetch 0x100: IDLE grant cycle ignores mem_ready_in, two wait cycles, ready in cycle 4
        sb_q.push_back(mk(1'b0, 32'hDEAD_BEEF, 1'b0));
        sample();
        chk("fetch_idle_no_ready", 32'(instr_ready_out), 32'd0);
        chk("fetch_idle_no_read", 32'(mem_read_out), 32'd0);
        next();
        mem_ready_in = 1'b0;
        sample();
        chk("fetch_addr", mem_address_out, 32'h100);
        chk("fetch_rd_wr", {30'd0, mem_read_out, mem_write_out}, 32'd2);
        next();
        sample();
        chk("fetch_wait_no_ready", 32'(instr_ready_out), 32'd0);
        next();
        mem_ready_in      = 1'b1;
        mem_read_value_in = 32'hDEAD_BEEF;
        sample();
        chk("fetch_ready_cycle4", 32'(instr_ready_out), 32'd1);
        chk("fetch_value", instr_read_value_out, 32'hDEAD_BEEF);
        next();

        // Simultaneous store and fetch: DATA first, INSTR waits then follows
        instr_address_in    = 32'h300;
        instr_read_in       = 1'b1;
        data_address_in     = 32'h200;
        data_write_in       = 1'b1;
        data_write_mask_in  = 4'b0011;
        data_write_value_in = 32'hCAFE_F00D;
        mem_ready_in        = 1'b0;
        sb_q.push_back(mk(1'b1, 32'h1111_1111, 1'b0));
        sb_q.push_back(mk(1'b0, 32'h2222_2222, 1'b0));
        sample();
        all_zero("tie_idle");
        next();
        mem_ready_in      = 1'b1;
        mem_read_value_in = 32'h1111_1111;
        sample();
        chk("tie_store_addr", mem_address_out, 32'h200);
        chk("tie_store_wr", {30'd0, mem_read_out, mem_write_out}, 32'd1);
        chk("tie_store_mask", 32'(mem_write_mask_out), 32'h3);
        chk("tie_store_val", mem_write_value_out, 32'hCAFE_F00D);
        chk("tie_instr_waits", 32'(instr_ready_out), 32'd0);
        next();
        data_write_in     = 1'b0;
        mem_read_value_in = 32'h2222_2222;
        sample();
        chk("tie_idle2_no_ready", 32'(instr_ready_out), 32'd0);
        next();
        sample();
        chk("tie_fetch_addr", mem_address_out, 32'h300);
        chk("tie_fetch_ready", 32'(instr_ready_out), 32'd1);
        next();

        // Both masters request continuously, memory always ready
        instr_address_in  = 32'h710;
        data_address_in   = 32'h700;
        data_read_in      = 1'b1;
        mem_read_value_in = 32'h3333_3333;
`ifdef RV32_ARB_ROUND_ROBIN_EN
        sb_q.push_back(mk(1'b1, 32'h3333_3333, 1'b0));
        sb_q.push_back(mk(1'b0, 32'h3333_3333, 1'b0));
        sb_q.push_back(mk(1'b1, 32'h3333_3333, 1'b0));
`else
        sb_q.push_back(mk(1'b1, 32'h3333_3333, 1'b0));
        sb_q.push_back(mk(1'b1, 32'h3333_3333, 1'b0));
        sb_q.push_back(mk(1'b1, 32'h3333_3333, 1'b0));
`endif
        nready = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (instr_ready_out || data_ready_out) nready++;
            next();
        end
        chk("b2b_ready_count", 32'(nready), 32'd3);
        instr_read_in = 1'b0;
        data_read_in  = 1'b0;
        sample();
        all_zero("b2b_idle");
        next();

        // Timeout: four wait cycles, then forced completion with bus error
        data_address_in = 32'h400;
        data_read_in    = 1'b1;
        mem_ready_in    = 1'b0;
        sb_q.push_back(mk(1'b1, 32'hFFFF_FFFF, 1'b1));
        sample();
        next();
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("to_wait_read", 32'(mem_read_out), 32'd1);
            chk("to_wait_no_err", {30'd0, data_ready_out, bus_error_out}, 32'd0);
            next();
        end
        sample();
        chk("to_ready", 32'(data_ready_out), 32'd1);
        chk("to_value", data_read_value_out, 32'hFFFF_FFFF);
        chk("to_bus_error", 32'(bus_error_out), 32'd1);
        chk("to_read_forced_low", 32'(mem_read_out), 32'd0);
        next();
        data_read_in = 1'b0;
        sample();
        all_zero("to_after");
        next();

        // Reset during a DATA store drops it silently; next request starts from IDLE
        data_address_in = 32'h500;
        data_write_in   = 1'b1;
        sample();
        next();
        sample();
        chk("rst_store_active", 32'(mem_write_out), 32'd1);
        #2;
        reset_ = 1'b0;
        #1;
        all_zero("rst_async");
        next();
        sample();
        all_zero("rst_held");
        next();
        data_write_in   = 1'b0;
        data_read_in    = 1'b1;
        data_address_in = 32'h600;
        mem_ready_in    = 1'b1;
        mem_read_value_in = 32'h6666_6666;
        reset_          = 1'b1;
        sb_q.push_back(mk(1'b1, 32'h6666_6666, 1'b0));
        sample();
        all_zero("rst_rearb_idle");
        next();
        sample();
        chk("rst_rearb_addr", mem_address_out, 32'h600);
        chk("rst_rearb_ready", 32'(data_ready_out), 32'd1);
        next();
        data_read_in = 1'b0;
        sample();
        next();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32_bus_arbiter.md
RV32_BUS_ARBITER -- requirements
Module: rv32_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max wait cycles for mem_ready_in per granted transaction (legal range 1..65535).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_address_in  in  32  fetch address from core.
REQ-005 SHALL have port instr_read_in  in  1  fetch request, held until instr_ready_out.
REQ-006 SHALL have port instr_read_value_out  out  32  fetch data, valid with instr_ready_out.
REQ-007 SHALL have port instr_ready_out  out  1  fetch complete.
REQ-008 SHALL have port data_address_in  in  32  load/store address.
REQ-009 SHALL have ports data_read_in and data_write_in  in  1 each  load/store request, mutually exclusive, held until data_ready_out.
REQ-010 SHALL have ports data_write_mask_in (in, 4) and data_write_value_in (in, 32)  store byte mask and store data.
REQ-011 SHALL have ports data_read_value_out (out, 32) and data_ready_out (out, 1)  load data and load/store complete.
REQ-012 SHALL have ports mem_address_out (out, 32), mem_read_out (out, 1), mem_write_out (out, 1), mem_write_mask_out (out, 4), mem_write_value_out (out, 32)  shared memory request.
REQ-013 SHALL have ports mem_read_value_in (in, 32) and mem_ready_in (in, 1)  shared memory response.
REQ-014 SHALL have port bus_error_out  out  1  one-cycle pulse on timeout.

Function
REQ-015 SHALL implement FSM with states IDLE, INSTR, DATA.
REQ-016 In IDLE: mem_read_out, mem_write_out, mem_write_mask_out, mem_address_out, mem_write_value_out all 0; both ready outputs 0.
REQ-017 In IDLE with request pending: next state INSTR or DATA per arbitration (REQ-022/REQ-031); grant takes effect one cycle after request first seen.
REQ-018 In INSTR: mem_address_out=instr_address_in, mem_read_out=1, mem_write_out=0, mask and write value 0.
REQ-019 In DATA: mem_* outputs pass data_* inputs combinationally.
REQ-020 While granted, mem_ready_in=1 SHALL assert the granted master's ready in the same cycle, read value = mem_read_value_in; next state IDLE.
REQ-021 Non-granted master's ready SHALL be 0; a transaction in progress is never preempted.
REQ-022 Default arbitration: DATA wins when both request in IDLE.
REQ-023 Wait counter (width for TIMEOUT) SHALL clear on entering INSTR/DATA and increment each granted cycle with mem_ready_in=0.
REQ-024 When counter equals TIMEOUT and mem_ready_in=0: granted master's ready=1, its read value 32'hFFFFFFFF, bus_error_out=1, mem_read_out/mem_write_out forced 0 that cycle; next state IDLE.
REQ-025 mem_ready_in in IDLE SHALL be ignored.
REQ-026 Minimum transaction: 2 cycles (IDLE grant cycle + one access cycle); back-to-back requests from one master see no further penalty.

Reset
REQ-027 reset_ low SHALL immediately force state IDLE, counter 0, round-robin flag INSTR, all outputs 0.
REQ-028 Reset mid-transaction SHALL drop the request with no ready pulse; first grant after release follows REQ-017.

Configuration
REQ-029 Macro RV32_ARB_ROUND_ROBIN_EN SHALL select tie-break policy.
REQ-030 Undefined: fixed DATA priority per REQ-022; no last-grant state.
REQ-031 Defined: 1-bit last-grant register updated on each grant; simultaneous requests go to the master not last granted; reset value INSTR, so first tie grants DATA.

Verification
REQ-032 instr_read_in=1 addr 0x100, mem_ready_in=1 after 2 access cycles -> instr_ready_out high in cycle 4 with mem_read_value_in 0xDEADBEEF passed.
REQ-033 Both request same cycle, store 0x200 mask 4'b0011 -> DATA granted first, mem_write_out=1, instr waits; then INSTR granted.
REQ-034 Both masters request continuously, RV32_ARB_ROUND_ROBIN_EN defined -> grants alternate DATA, INSTR, DATA; undefined -> DATA every time.
REQ-035 TIMEOUT=4, mem_ready_in held 0 -> after 4 wait cycles data_ready_out=1, data_read_value_out=0xFFFFFFFF, bus_error_out pulses once, state IDLE.
REQ-036 reset_ dropped during DATA -> all outputs 0 asynchronously, no ready, next request re-arbitrated from IDLE.
